// File: rtl/bsg_front_side_bus_hop_out_no_fc.sv
// Output stage of one front-side-bus hop: registers one word per cycle toward the
// next hop, giving upstream pass-through strict priority over queued local words.
module bsg_front_side_bus_hop_out_no_fc #(
  parameter int width_p     = 8,
  parameter int local_els_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  input  logic [width_p-1:0] local_data_i,
  input  logic               local_v_i,
  output logic               local_ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o
);

  localparam int ptr_w_lp = (local_els_p > 1) ? $clog2(local_els_p) : 1;
  localparam int cnt_w_lp = $clog2(local_els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(local_els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(local_els_p);

  // Handshakes: a local word transfers on a cycle where local_v_i & local_ready_o
  // are both high; local_ready_o never looks at local_v_i. Pass-through (v_i) has
  // no ready at all and is consumed in the cycle it is presented.

  logic [width_p-1:0]  mem_r [local_els_p];
  logic [ptr_w_lp-1:0] rd_ptr_r, wr_ptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                enq, deq, fifo_empty;
  logic [ptr_w_lp-1:0] rd_ptr_n, wr_ptr_n;
  logic [cnt_w_lp-1:0] count_n;

  assign fifo_empty    = (count_r == '0);
  assign local_ready_o = (count_r < full_cnt_lp) & ~reset_i;
  assign enq           = local_v_i & local_ready_o;
  // Head only leaves on an idle upstream slot; a word written this cycle is not yet counted.
  assign deq           = ~v_i & ~fifo_empty & ~reset_i;

  always_comb begin
    rd_ptr_n = rd_ptr_r;
    wr_ptr_n = wr_ptr_r;
    count_n  = count_r;
    if (enq) begin
      wr_ptr_n = (wr_ptr_r == last_ptr_lp) ? '0 : wr_ptr_r + 1'b1;
    end
    if (deq) begin
      rd_ptr_n = (rd_ptr_r == last_ptr_lp) ? '0 : rd_ptr_r + 1'b1;
    end
    if (enq & ~deq) begin
      count_n = count_r + 1'b1;
    end else if (deq & ~enq) begin
      count_n = count_r - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      v_o      <= 1'b0;
    end else begin
      rd_ptr_r <= rd_ptr_n;
      wr_ptr_r <= wr_ptr_n;
      count_r  <= count_n;
      v_o      <= v_i | ~fifo_empty;
    end
  end

  // Storage and data_o carry no reset; data_o holds across idle cycles.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_r[wr_ptr_r] <= local_data_i;
    end
    if (~reset_i) begin
      if (v_i) begin
        data_o <= data_i;
      end else if (deq) begin
        data_o <= mem_r[rd_ptr_r];
      end
    end
  end

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out_no_fc.sv
// Directed bench for the hop output stage: a depth-2 instance for the main scenarios
// and a depth-3 instance for pointer wrap-around with upstream gaps.
module tb_bsg_front_side_bus_hop_out_no_fc;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d2_data, d2_ldata, d2_data_o;
  logic       d2_v, d2_lv, d2_lready, d2_v_o;
  logic [7:0] d3_data, d3_ldata, d3_data_o;
  logic       d3_v, d3_lv, d3_lready, d3_v_o;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  bsg_front_side_bus_hop_out_no_fc #(.width_p(8), .local_els_p(2)) dut2 (
    .clk_i(clk), .reset_i(reset), .data_i(d2_data), .v_i(d2_v),
    .local_data_i(d2_ldata), .local_v_i(d2_lv), .local_ready_o(d2_lready),
    .data_o(d2_data_o), .v_o(d2_v_o)
  );

  bsg_front_side_bus_hop_out_no_fc #(.width_p(8), .local_els_p(3)) dut3 (
    .clk_i(clk), .reset_i(reset), .data_i(d3_data), .v_i(d3_v),
    .local_data_i(d3_ldata), .local_v_i(d3_lv), .local_ready_o(d3_lready),
    .data_o(d3_data_o), .v_o(d3_v_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle2;
    d2_v = 1'b0; d2_data = 8'h00; d2_lv = 1'b0; d2_ldata = 8'h00;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle2();
    d3_v = 1'b0; d3_data = 8'h00; d3_lv = 1'b0; d3_ldata = 8'h00;
    tick(); tick();
    total++; if (d2_v_o !== 1'b0) begin bad++; $display("FAIL reset_v_o act=%b exp=0", d2_v_o); end
    total++; if (d2_lready !== 1'b0) begin bad++; $display("FAIL reset_ready act=%b exp=0", d2_lready); end
    total++; if (d3_v_o !== 1'b0) begin bad++; $display("FAIL reset_v_o3 act=%b exp=0", d3_v_o); end
    reset = 1'b0;
    #1;
    total++; if (d2_lready !== 1'b1) begin bad++; $display("FAIL reset_release_ready act=%b exp=1", d2_lready); end
  endtask

  task automatic test_pass_through;
    logic [7:0] pat [3];
    pat[0] = 8'hA1; pat[1] = 8'hA2; pat[2] = 8'hA3;
    for (int i = 0; i < 3; i++) begin
      d2_v = 1'b1; d2_data = pat[i];
      tick();
      total++; if (d2_v_o !== 1'b1 || d2_data_o !== pat[i]) begin
        bad++; $display("FAIL pass_word%0d act=%b/%h exp=1/%h", i, d2_v_o, d2_data_o, pat[i]);
      end
    end
    d2_v = 1'b0; d2_data = 8'h5A;
    tick();
    total++; if (d2_v_o !== 1'b0 || d2_data_o !== 8'hA3) begin
      bad++; $display("FAIL pass_hold act=%b/%h exp=0/a3", d2_v_o, d2_data_o);
    end
    idle2();
  endtask

  task automatic test_local_only;
    logic       ev [5];
    logic [7:0] ed [5];
    ev[1] = 1'b0; ev[2] = 1'b1; ev[3] = 1'b1; ev[4] = 1'b0;
    ed[2] = 8'h10; ed[3] = 8'h11; ed[4] = 8'h11;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        total++; if (d2_v_o !== ev[c] || (ev[c] && d2_data_o !== ed[c]) || (c == 4 && d2_data_o !== ed[c])) begin
          bad++; $display("FAIL local_out c%0d act=%b/%h exp=%b/%h", c, d2_v_o, d2_data_o, ev[c], ed[c]);
        end
      end
      total++; if (d2_lready !== 1'b1) begin bad++; $display("FAIL local_ready c%0d act=%b exp=1", c, d2_lready); end
      d2_v  = 1'b0;
      d2_lv = (c == 0 || c == 1);
      d2_ldata = (c == 0) ? 8'h10 : 8'h11;
      tick();
    end
    idle2();
  endtask

  task automatic test_full_priority;
    logic       exp_v, exp_r;
    logic [7:0] exp_d;
    for (int c = 0; c < 14; c++) begin
      exp_r = (c <= 2 || c >= 11);
      if (c > 0) begin
        exp_v = (c <= 12);
        if (c <= 10)      exp_d = 8'hC0 + 8'(c - 1);
        else if (c == 11) exp_d = 8'h20;
        else              exp_d = 8'h21;
        total++; if (d2_v_o !== exp_v || d2_data_o !== exp_d) begin
          bad++; $display("FAIL full_out c%0d act=%b/%h exp=%b/%h", c, d2_v_o, d2_data_o, exp_v, exp_d);
        end
      end
      total++; if (d2_lready !== exp_r) begin
        bad++; $display("FAIL full_ready c%0d act=%b exp=%b", c, d2_lready, exp_r);
      end
      d2_v     = (c <= 9);
      d2_data  = 8'hC0 + 8'(c);
      d2_lv    = (c >= 1 && c <= 3);
      d2_ldata = 8'h1F + 8'(c);
      tick();
    end
    idle2();
  endtask

  task automatic test_interleave;
    logic       ev [6];
    logic [7:0] ed [6];
    ev[1] = 1'b1; ed[1] = 8'hB0;
    ev[2] = 1'b1; ed[2] = 8'h30;
    ev[3] = 1'b1; ed[3] = 8'hB1;
    ev[4] = 1'b1; ed[4] = 8'h31;
    ev[5] = 1'b0; ed[5] = 8'h31;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        total++; if (d2_v_o !== ev[c] || d2_data_o !== ed[c]) begin
          bad++; $display("FAIL interleave c%0d act=%b/%h exp=%b/%h", c, d2_v_o, d2_data_o, ev[c], ed[c]);
        end
      end
      total++; if (d2_lready !== 1'b1) begin bad++; $display("FAIL interleave_ready c%0d act=%b exp=1", c, d2_lready); end
      d2_v     = (c == 0 || c == 2);
      d2_data  = (c == 0) ? 8'hB0 : 8'hB1;
      d2_lv    = (c <= 1);
      d2_ldata = (c == 0) ? 8'h30 : 8'h31;
      tick();
    end
    idle2();
  endtask

  task automatic test_reset_mid;
    d2_v = 1'b1; d2_data = 8'hD0; d2_lv = 1'b1; d2_ldata = 8'h50;
    tick();
    d2_data = 8'hD1; d2_ldata = 8'h51;
    tick();
    total++; if (d2_lready !== 1'b0) begin bad++; $display("FAIL mid_full_ready act=%b exp=0", d2_lready); end
    reset = 1'b1; d2_data = 8'hEE; d2_ldata = 8'h52;
    #1;
    total++; if (d2_lready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready act=%b exp=0", d2_lready); end
    tick();
    total++; if (d2_v_o !== 1'b0) begin bad++; $display("FAIL mid_reset_v_o act=%b exp=0", d2_v_o); end
    reset = 1'b0;
    idle2();
    #1;
    total++; if (d2_lready !== 1'b1) begin bad++; $display("FAIL mid_after_ready act=%b exp=1", d2_lready); end
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (d2_v_o !== 1'b0) begin bad++; $display("FAIL mid_stale c%0d act=%b/%h exp=0", c, d2_v_o, d2_data_o); end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_q [$];
    logic [7:0] exp_d, prev_d;
    logic       prev_v, prev_deq, enq, deq;
    int         sent, cnt_m;
    sent = 0; cnt_m = 0; prev_v = 1'b0; prev_deq = 1'b0; prev_d = 8'h00;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (prev_v) begin
        total++; if (d3_v_o !== 1'b1 || d3_data_o !== prev_d) begin
          bad++; $display("FAIL wrap_upstream c%0d act=%b/%h exp=1/%h", cyc, d3_v_o, d3_data_o, prev_d);
        end
      end else if (prev_deq) begin
        exp_d = exp_q.pop_front();
        total++; if (d3_v_o !== 1'b1 || d3_data_o !== exp_d) begin
          bad++; $display("FAIL wrap_local c%0d act=%b/%h exp=1/%h", cyc, d3_v_o, d3_data_o, exp_d);
        end
      end else begin
        total++; if (d3_v_o !== 1'b0) begin bad++; $display("FAIL wrap_idle c%0d act=%b exp=0", cyc, d3_v_o); end
      end
      total++; if (d3_lready !== (cnt_m < 3)) begin
        bad++; $display("FAIL wrap_ready c%0d act=%b exp=%b", cyc, d3_lready, (cnt_m < 3));
      end
      d3_v     = (cyc < 50) ? 1'($urandom_range(0, 1)) : 1'b0;
      d3_data  = 8'h80 + 8'(cyc);
      d3_lv    = (sent < 10);
      d3_ldata = 8'h40 + 8'(sent);
      enq = d3_lv && (cnt_m < 3);
      deq = !d3_v && (cnt_m > 0);
      if (enq) begin
        exp_q.push_back(d3_ldata);
        sent++;
      end
      cnt_m    = cnt_m + int'(enq) - int'(deq);
      prev_v   = d3_v;
      prev_d   = d3_data;
      prev_deq = deq;
      tick();
    end
    total++; if (sent != 10 || exp_q.size() != 0) begin
      bad++; $display("FAIL wrap_drain sent=%0d pending=%0d exp=10/0", sent, exp_q.size());
    end
    d3_v = 1'b0; d3_lv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_local_only();
    test_full_priority();
    test_interleave();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
